// File: rtl/uart_receiver_pkg.sv
// Shared UART receiver definitions: FSM state encoding, frame width, and bit-counter markers.
package uart_receiver_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_e;

    // Bit-counter value marking "stop bit already sampled as 0, waiting for line to go idle".
    localparam logic [3:0] BIT_CNT_WAIT = 4'hF;

    // Index of the last data bit, as a 4-bit bit-counter value.
    localparam logic [3:0] BIT_CNT_LAST = 4'(UART_DATA_BITS - 1);

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Reloadable baud down-counter for the UART receiver. A load arms a strobe HALF clocks later;
// every strobe while enabled re-arms the next one CLKS_PER_BIT clocks later.
module uart_rx_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick
);

    // The counter holds "clocks remaining minus one", so the strobe lands exactly
    // HALF / CLKS_PER_BIT edges after the load / previous strobe.
    localparam logic [7:0] LP_HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] LP_FULL_M1 = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    assign o_tick = i_en && (r_cnt == 8'd0);

    // Counter: load on frame start, reload on each strobe, otherwise count down.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= LP_HALF_M1;
        end else if (i_en) begin
            r_cnt <= o_tick ? LP_FULL_M1 : r_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1, MSB first, one-entry holding register with valid/rd handshake,
// one-cycle frame-error pulse and sticky overrun flag.
// Optional: define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (adds 2 clocks).
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rx,
    input  logic                      i_rd,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_frame_err,
    output logic                      o_overrun
);

    logic                      w_rx_s;
    logic                      w_tick;
    logic                      w_load;
    logic                      w_baud_en;
    logic                      w_shift;
    logic                      w_stop_sample;
    logic                      w_deliver;
    logic                      w_frame_bad;
    rx_state_e                 r_state;
    rx_state_e                 w_state_d;
    logic [3:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer, idle-high out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    assign w_rx_s = r_sync[1];
`else
    assign w_rx_s = i_rx;
`endif

    uart_rx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (w_load),
        .i_en   (w_baud_en),
        .o_tick (w_tick)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) w_state_d = RX_START;
            end
            RX_START: begin
                // A high line at mid-start-bit is a glitch, not a frame.
                if (w_tick) w_state_d = w_rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_tick && (r_bit_cnt == BIT_CNT_LAST)) w_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (r_bit_cnt == BIT_CNT_WAIT) begin
                    if (w_rx_s) w_state_d = RX_IDLE;
                end else if (w_tick && w_rx_s) begin
                    w_state_d = RX_IDLE;
                end
            end
            default: w_state_d = RX_IDLE;
        endcase
    end

    // FSM outputs: counter control and sample-point strobes.
    always_comb begin
        w_load        = (r_state == RX_IDLE) && !w_rx_s;
        w_baud_en     = (r_state != RX_IDLE);
        w_shift       = (r_state == RX_DATA) && w_tick;
        w_stop_sample = (r_state == RX_STOP) && (r_bit_cnt != BIT_CNT_WAIT) && w_tick;
        w_deliver     = w_stop_sample && w_rx_s;
        w_frame_bad   = w_stop_sample && !w_rx_s;
    end

    // Shift register and bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= 4'd0;
        end else if (w_load) begin
            r_bit_cnt <= 4'd0;
        end else if (w_shift) begin
            r_shreg   <= {r_shreg[UART_DATA_BITS-2:0], w_rx_s};
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (w_frame_bad) begin
            r_bit_cnt <= BIT_CNT_WAIT;
        end
    end

    // Holding register, valid/rd handshake, error flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            if (w_deliver) begin
                if (!r_valid || i_rd) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                    if (r_valid) r_overrun <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (i_rd && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: two instances (CLKS_PER_BIT 4 and 2), directed
// scenarios plus randomized frames, checked every cycle against an event-based model.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int CPB0 = 4;
    localparam int CPB1 = 2;

    typedef struct {
        int         lane;
        int         cyc;
        bit         bad;
        logic [7:0] b;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      rx;
    logic [1:0]      rd_rand;
    logic [1:0]      rd_man;
    logic [1:0]      rd_auto;
    logic [1:0]      w_rd;
    logic [1:0][7:0] data;
    logic [1:0]      valid;
    logic [1:0]      ferr;
    logic [1:0]      ovr;
    int              rd_pct [2];

    ev_t             evq[$];
    int              cyc = 0;
    logic [1:0]      m_valid;
    logic [1:0]      m_ferr;
    logic [1:0]      m_ovr;
    logic [1:0][7:0] m_data;
    bit              m_hit;
    bit              m_bad;
    logic [7:0]      m_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign w_rd = rd_rand | rd_man;

    uart_receiver #(.CLKS_PER_BIT(CPB0)) u_dut0 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx[0]),
        .i_rd       (w_rd[0]),
        .o_data     (data[0]),
        .o_valid    (valid[0]),
        .o_frame_err(ferr[0]),
        .o_overrun  (ovr[0])
    );

    uart_receiver #(.CLKS_PER_BIT(CPB1)) u_dut1 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx[1]),
        .i_rd       (w_rd[1]),
        .o_data     (data[1]),
        .o_valid    (valid[1]),
        .o_frame_err(ferr[1]),
        .o_overrun  (ovr[1])
    );

    function automatic int cpb(int l);
        return (l == 0) ? CPB0 : CPB1;
    endfunction

    // Model: each frame the stimulus sends is an event at its stop-sample edge; the
    // handshake rules are applied to those events and the rd input every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = '0;
            m_ferr  = '0;
            m_ovr   = '0;
            m_data  = '0;
            evq.delete();
        end else begin
            cyc = cyc + 1;
            for (int l = 0; l < 2; l++) begin
                m_hit = 1'b0;
                m_bad = 1'b0;
                m_b   = 8'h00;
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].lane == l && evq[i].cyc == cyc) begin
                        m_hit = 1'b1;
                        m_bad = evq[i].bad;
                        m_b   = evq[i].b;
                        evq.delete(i);
                    end
                end
                m_ferr[l] = m_hit && m_bad;
                if (m_hit && !m_bad) begin
                    if (!m_valid[l] || w_rd[l]) begin
                        if (m_valid[l]) m_ovr[l] = 1'b0;
                        m_data[l]  = m_b;
                        m_valid[l] = 1'b1;
                    end else begin
                        m_ovr[l] = 1'b1;
                    end
                end else if (w_rd[l] && m_valid[l]) begin
                    m_valid[l] = 1'b0;
                    m_ovr[l]   = 1'b0;
                end
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < 2; l++) begin
                vectors++;
                if ({valid[l], ferr[l], ovr[l], data[l]} !==
                    {m_valid[l], m_ferr[l], m_ovr[l], m_data[l]}) begin
                    errors++;
                    $display("FAIL lane%0d cyc%0d: got v=%b fe=%b ov=%b d=%h, want v=%b fe=%b ov=%b d=%h",
                             l, cyc, valid[l], ferr[l], ovr[l], data[l],
                             m_valid[l], m_ferr[l], m_ovr[l], m_data[l]);
                end
            end
        end
    end

    // Consumer: random, automatic (pop whatever is valid), or manual pulses.
    initial begin
        rd_rand = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int l = 0; l < 2; l++) begin
                rd_rand[l] = rd_auto[l] ? valid[l] : ($urandom_range(99) < rd_pct[l]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int l, input int n);
        rx[l] = 1'b1;
        step(n);
    endtask

    // Drives one frame starting now (just after an edge) and records its expected outcome.
    task automatic send(input int l, input logic [7:0] b, input bit stop_ok, input int extra_low);
        logic [9:0] bits;
        ev_t        e;
        bits   = {1'b0, b, stop_ok};
        e.lane = l;
        e.cyc  = cyc + 1 + LAT + cpb(l) / 2 + 9 * cpb(l);
        e.bad  = !stop_ok;
        e.b    = b;
        evq.push_back(e);
        for (int i = 9; i >= 0; i--) begin
            rx[l] = bits[i];
            step(cpb(l));
        end
        if (!stop_ok) step(extra_low);
        rx[l] = 1'b1;
    endtask

    task automatic pop(input int l);
        rd_man[l] = 1'b1;
        step(1);
        rd_man[l] = 1'b0;
    endtask

    int k;
    int t;

    initial begin
        rx      = '1;
        rd_man  = '0;
        rd_auto = '0;
        rd_pct  = '{0, 0};
        rst_n   = 1'b0;
        step(3);
        chk("reset data", data[0], 8'h00);
        chk("reset valid", {7'd0, valid[0]}, 8'h00);
        rst_n = 1'b1;
        step(1);

        // 1: 0xA5 at CPB=4; stop sample is 1 + HALF(2) + 9*4 = 39 edges after the start drive.
        k = cyc;
        fork
            send(0, 8'hA5, 1'b1, 0);
            begin
                wait (cyc >= k + 38 + LAT);
                @(negedge clk);
                chk("t1 valid before stop", {7'd0, valid[0]}, 8'h00);
                @(negedge clk);
                chk("t1 valid at stop", {7'd0, valid[0]}, 8'h01);
                chk("t1 data", data[0], 8'hA5);
                chk("t1 ferr", {7'd0, ferr[0]}, 8'h00);
            end
        join
        pop(0);
        chk("t1 pop valid", {7'd0, valid[0]}, 8'h00);

        // 2: one-cycle low glitch.
        rx[0] = 1'b0;
        step(1);
        idle(0, 8);
        chk("t2 glitch valid", {7'd0, valid[0]}, 8'h00);

        // 3: 0x81 with bad stop held low 12 extra cycles, then 0x42.
        k = cyc;
        fork
            send(0, 8'h81, 1'b0, 12);
            begin
                wait (cyc >= k + 39 + LAT);
                @(negedge clk);
                chk("t3 ferr pulse", {7'd0, ferr[0]}, 8'h01);
                chk("t3 valid", {7'd0, valid[0]}, 8'h00);
                @(negedge clk);
                chk("t3 ferr one cycle", {7'd0, ferr[0]}, 8'h00);
            end
        join
        idle(0, 3);
        send(0, 8'h42, 1'b1, 0);
        idle(0, 4);
        chk("t3 data after err", data[0], 8'h42);
        pop(0);

        // 4: two frames with no rd -> overrun, first byte kept.
        send(0, 8'h3C, 1'b1, 0);
        send(0, 8'hC3, 1'b1, 0);
        idle(0, 4);
        chk("t4 data kept", data[0], 8'h3C);
        chk("t4 overrun", {7'd0, ovr[0]}, 8'h01);
        pop(0);
        chk("t4 pop valid", {7'd0, valid[0]}, 8'h00);
        chk("t4 pop overrun", {7'd0, ovr[0]}, 8'h00);

        // 5: reset in the middle of 0xFF while a byte is held.
        send(0, 8'h11, 1'b1, 0);
        idle(0, 2);
        rx[0] = 1'b0;
        step(CPB0);
        rx[0] = 1'b1;
        step(4 * CPB0 + 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 rst data", data[0], 8'h00);
        chk("t5 rst valid", {7'd0, valid[0]}, 8'h00);
        chk("t5 rst flags", {6'd0, ferr[0], ovr[0]}, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(1);
        send(0, 8'h0F, 1'b1, 0);
        idle(0, 4);
        chk("t5 data after reset", data[0], 8'h0F);
        pop(0);

        // 6: CPB=2 back-to-back 0x55, 0xAA; stop samples at 1+1+18 = 20 and 40 edges.
        rd_auto[1] = 1'b1;
        k = cyc;
        fork
            begin
                send(1, 8'h55, 1'b1, 0);
                send(1, 8'hAA, 1'b1, 0);
            end
            begin
                wait (cyc >= k + 19 + LAT);
                @(negedge clk);
                chk("t6 valid before", {7'd0, valid[1]}, 8'h00);
                @(negedge clk);
                chk("t6 valid 1st", {7'd0, valid[1]}, 8'h01);
                chk("t6 data 1st", data[1], 8'h55);
                wait (cyc >= k + 39 + LAT);
                @(negedge clk);
                chk("t6 valid between", {7'd0, valid[1]}, 8'h00);
                @(negedge clk);
                chk("t6 valid 2nd", {7'd0, valid[1]}, 8'h01);
                chk("t6 data 2nd", data[1], 8'hAA);
            end
        join
        idle(1, 4);
        rd_auto[1] = 1'b0;

        // Randomized frames, stop errors, gaps and consumer behaviour on both lanes.
        for (int l = 0; l < 2; l++) begin
            rd_pct[l] = 30;
            repeat (60) begin
                logic [7:0] b;
                bit         ok;
                b  = 8'($urandom);
                ok = ($urandom_range(9) != 0);
                send(l, b, ok, $urandom_range(3));
                t = ok ? $urandom_range(3) : 1 + $urandom_range(3);
                idle(l, t);
            end
            idle(l, 20);
            rd_pct[l] = 0;
        end

        step(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
